// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side serial link responder.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      CMD_READ16  = 2'b00,
      CMD_WRITE8  = 2'b01,
      CMD_WRITE16 = 2'b10,
      CMD_RSVD    = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      RCV_IDLE    = 2'b00,
      RCV_CMD     = 2'b01,
      RCV_PAYLOAD = 2'b10
   } rcv_state_e;

   typedef enum logic [1:0] {
      REP_IDLE  = 2'b00,
      REP_WAIT  = 2'b01,
      REP_START = 2'b10,
      REP_DATA  = 2'b11
   } rep_state_e;

   localparam logic [1:0] SYM_IDLE  = 2'b00;
   localparam logic [1:0] SYM_START = 2'b01;

   localparam int unsigned PAYLOAD_W8     = 4;
   localparam int unsigned PAYLOAD_LONG   = 8;
   localparam int unsigned RX_DATA_CYCLES = 8;
   localparam int unsigned CNT_W          = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// Byte memory: lo/hi byte write with wrapping hi address, combinational
// 16-bit read of A/A+1, and a combinational backdoor byte read.
module mem_responder_ram #(
   parameter int unsigned ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we_lo,
   input  logic                 we_hi,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [15:0]          wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [15:0]          rdata_c,
   input  logic [ADDR_BITS-1:0] dbg_addr,
   output logic [7:0]           dbg_data
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   logic [7:0]           mem [DEPTH];
   logic [ADDR_BITS-1:0] waddr_hi;
   logic [ADDR_BITS-1:0] raddr_hi;

   assign waddr_hi = waddr + ADDR_BITS'(1);
   assign raddr_hi = raddr + ADDR_BITS'(1);

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_lo) mem[waddr]    <= wdata[7:0];
      if (we_hi) mem[waddr_hi] <= wdata[15:8];
   end

   assign rdata_c  = {mem[raddr_hi], mem[raddr]};
   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the serial CPU<->memory link: receives TX commands,
// applies writes to a local byte memory and streams READ_16 replies on RX.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned NSHIFT      = 2,
   parameter int unsigned ADDR_BITS   = 8,
   parameter int unsigned REPLY_DELAY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSHIFT-1:0]    tx_pins,
   output logic [NSHIFT-1:0]    rx_pins,
   output logic                 busy,
   output logic                 overrun,
   output logic [15:0]          last_addr,
   input  logic [ADDR_BITS-1:0] dbg_addr,
   output logic [7:0]           dbg_data
);

   rcv_state_e            rcv_state;
   rep_state_e            rep_state;
   cmd_e                  cmd;
   logic [CNT_W-1:0]      pcnt;
   logic [CNT_W-1:0]      rcnt;
   logic [15-NSHIFT:0]    shreg;
   logic [15:0]           reply;

   logic [15:0]           payload_c;
   logic                  last_cycle_c;
   logic                  read_commit_c;
   logic                  w8_commit_c;
   logic                  w16_commit_c;
   logic [15:0]           rd_data_c;
   logic [15:0]           wdata_c;

   // Payload arrives LSB first; the current symbol completes the top slot.
   assign payload_c     = {tx_pins, shreg};
   assign last_cycle_c  = (rcv_state == RCV_PAYLOAD) && (pcnt == '0);
   assign read_commit_c = last_cycle_c && (cmd == CMD_READ16);
   assign w8_commit_c   = last_cycle_c && (cmd == CMD_WRITE8);
   assign w16_commit_c  = last_cycle_c && (cmd == CMD_WRITE16);
   assign wdata_c       = w8_commit_c ? {8'h00, payload_c[15:8]} : payload_c;

   assign busy = (rcv_state != RCV_IDLE) || (rep_state != REP_IDLE);

   mem_responder_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk      (clk),
      .we_lo    (w8_commit_c | w16_commit_c),
      .we_hi    (w16_commit_c),
      .waddr    (last_addr[ADDR_BITS-1:0]),
      .wdata    (wdata_c),
      .raddr    (payload_c[ADDR_BITS-1:0]),
      .rdata_c  (rd_data_c),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // Receive FSM: start symbol, command symbol, then 4 or 8 payload symbols.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcv_state <= RCV_IDLE;
         cmd       <= CMD_READ16;
         pcnt      <= '0;
         shreg     <= '0;
      end else begin
         case (rcv_state)
            RCV_IDLE: begin
               if (tx_pins[0]) rcv_state <= RCV_CMD;
            end
            RCV_CMD: begin
               cmd       <= cmd_e'(tx_pins);
               pcnt      <= (cmd_e'(tx_pins) == CMD_WRITE8) ? CNT_W'(PAYLOAD_W8 - 1)
                                                            : CNT_W'(PAYLOAD_LONG - 1);
               rcv_state <= RCV_PAYLOAD;
            end
            RCV_PAYLOAD: begin
               shreg <= payload_c[15:NSHIFT];
               if (pcnt == '0) rcv_state <= RCV_IDLE;
               else            pcnt      <= pcnt - CNT_W'(1);
            end
            default: rcv_state <= RCV_IDLE;
         endcase
      end
   end

   // Reply FSM plus READ bookkeeping; a READ while a reply is in flight is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_state <= REP_IDLE;
         rx_pins   <= SYM_IDLE;
         overrun   <= 1'b0;
         last_addr <= '0;
         reply     <= '0;
         rcnt      <= '0;
      end else begin
         if (read_commit_c) begin
            last_addr <= payload_c;
            if (rep_state != REP_IDLE) overrun <= 1'b1;
         end
         case (rep_state)
            REP_IDLE: begin
               rx_pins <= SYM_IDLE;
               if (read_commit_c) begin
                  reply     <= rd_data_c;
                  rcnt      <= CNT_W'(REPLY_DELAY);
                  rep_state <= REP_WAIT;
               end
            end
            REP_WAIT: begin
               if (rcnt == '0) begin
                  rx_pins   <= SYM_START;
                  rep_state <= REP_START;
               end else begin
                  rcnt <= rcnt - CNT_W'(1);
               end
            end
            REP_START: begin
               rx_pins   <= reply[NSHIFT-1:0];
               reply     <= {NSHIFT'(0), reply[15:NSHIFT]};
               rcnt      <= CNT_W'(RX_DATA_CYCLES - 1);
               rep_state <= REP_DATA;
            end
            REP_DATA: begin
               if (rcnt == '0) begin
                  rx_pins   <= SYM_IDLE;
                  rep_state <= REP_IDLE;
               end else begin
                  rx_pins <= reply[NSHIFT-1:0];
                  reply   <= {NSHIFT'(0), reply[15:NSHIFT]};
                  rcnt    <= rcnt - CNT_W'(1);
               end
            end
            default: rep_state <= REP_IDLE;
         endcase
      end
   end

endmodule
